// File: rtl/bnn_pkg.sv
// Shared BNN definitions: the top-level phase encoding and the default load geometry.
// The phase value selects which block owns the datapath; the loader is active only in s_LOAD.
package bnn_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_LOAD    = 3'd1,
    s_LAYER_1 = 3'd2,
    s_LAYER_2 = 3'd3,
    s_LAYER_3 = 3'd4
  } state_t;

  localparam int N_PIX_BYTES = 98;
  localparam int N_WGT_BYTES = 9;

endpackage

// File: rtl/bnn_input_loader_if.sv
// Byte-wide valid/ready load channel feeding the BNN input loader.
// A byte moves on every cycle where data_valid and data_ready are both high.
interface bnn_input_loader_if;

  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/bnn_input_loader.sv
// Captures a binarised 28x28 image then the layer-one kernels; one byte per transfer, done 1 cycle after the last.
// data_ready is high only while loading in s_LOAD; bytes offered at any other time are ignored.
module bnn_input_loader
  import bnn_pkg::state_t;
  import bnn_pkg::s_LOAD;
#(
  parameter int N_PIX_BYTES = bnn_pkg::N_PIX_BYTES,
  parameter int N_WGT_BYTES = bnn_pkg::N_WGT_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  state_t                 state,
  bnn_input_loader_if.slave      ld,
  output logic [27:0][27:0]      pixels,
  output logic [7:0][2:0][2:0]   weights,
  output logic                   load_done
);

  localparam int PIX_W = N_PIX_BYTES * 8;
  localparam int WGT_W = N_WGT_BYTES * 8;
  localparam logic [6:0] PIX_LAST = 7'(N_PIX_BYTES - 1);
  localparam logic [6:0] WGT_LAST = 7'(N_WGT_BYTES - 1);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_PIX  = 2'd1,
    L_WGT  = 2'd2,
    L_DONE = 2'd3
  } ld_state_e;

  ld_state_e        fsm_q, fsm_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_q;
  logic [WGT_W-1:0] wgt_q;
  logic             ready;
  logic             xfer;

  assign xfer = ld.data_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= L_IDLE;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

  // Leaving s_LOAD wins over everything so a partial load is abandoned cleanly.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    if (state != s_LOAD) begin
      fsm_d = L_IDLE;
    end else begin
      case (fsm_q)
        L_IDLE: begin
          fsm_d = L_PIX;
          cnt_d = '0;
        end
        L_PIX: begin
          if (xfer) begin
            if (cnt_q == PIX_LAST) begin
              fsm_d = L_WGT;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        L_WGT: begin
          if (xfer) begin
            if (cnt_q == WGT_LAST) begin
              fsm_d = L_DONE;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
        end
        default: fsm_d = L_DONE;
      endcase
    end
  end

  always_comb begin
    ready     = 1'b0;
    load_done = 1'b0;
    case (fsm_q)
      L_PIX:   ready = (state == s_LOAD);
      L_WGT:   ready = (state == s_LOAD);
      L_DONE:  load_done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign ld.data_ready = ready;

  // Storage is untouched outside transfers so it stays stable for the layers after a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
      wgt_q <= '0;
    end else if (xfer && fsm_q == L_PIX) begin
      pix_q[{cnt_q, 3'b000} +: 8] <= ld.data_in;
    end else if (xfer && fsm_q == L_WGT) begin
      wgt_q[{cnt_q[3:0], 3'b000} +: 8] <= ld.data_in;
    end
  end

  assign pixels  = pix_q;
  assign weights = wgt_q;

endmodule

// File: tb/tb_bnn_input_loader.sv
// Directed bench for bnn_input_loader: golden flat image/kernel model plus a byte scoreboard.
module tb_bnn_input_loader;
  import bnn_pkg::*;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  state_t state;
  logic [27:0][27:0] pixels;
  logic [7:0][2:0][2:0] weights;
  logic load_done;

  bnn_input_loader_if ld ();

  bnn_input_loader dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .ld        (ld),
    .pixels    (pixels),
    .weights   (weights),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [783:0] pix_flat;
  logic [71:0]  wgt_flat;
  assign pix_flat = pixels;
  assign wgt_flat = weights;

  logic [783:0] exp_pix;
  logic [71:0]  exp_wgt;
  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [783:0] obs, input logic [783:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte, wait (bounded) for the transfer, then check where it landed.
  task automatic send_byte(input int k, input logic [7:0] b);
    exp_t e;
    logic got;
    logic [7:0] obs;
    got = 1'b0;
    sbq.push_back('{k, b});
    ld.data_valid = 1'b1;
    ld.data_in    = b;
    for (int n = 0; n < 40; n++) begin
      got = ld.data_ready;
      step();
      if (got) break;
    end
    check("xfer", {783'b0, got}, 784'd1);
    e = sbq.pop_front();
    if (got) begin
      if (e.idx < 98) begin
        exp_pix[e.idx*8 +: 8] = e.val;
        obs = pix_flat[e.idx*8 +: 8];
      end else begin
        exp_wgt[(e.idx-98)*8 +: 8] = e.val;
        obs = wgt_flat[(e.idx-98)*8 +: 8];
      end
      check("sb_byte", {776'b0, obs}, {776'b0, e.val});
    end
  endtask

  task automatic leave_load();
    ld.data_valid = 1'b0;
    state = s_IDLE;
    step();
  endtask

  logic [783:0] snap_pix;
  logic [71:0]  snap_wgt;
  int c0;

  initial begin
    rst = 1'b1;
    state = s_IDLE;
    ld.data_valid = 1'b1;
    ld.data_in = 8'hFF;
    exp_pix = '0;
    exp_wgt = '0;
    repeat (2) step();
    check("rst_pix", pix_flat, 784'd0);
    check("rst_wgt", {712'b0, wgt_flat}, 784'd0);
    check("rst_done", {783'b0, load_done}, 784'd0);
    check("rst_ready", {783'b0, ld.data_ready}, 784'd0);
    rst = 1'b0;
    ld.data_valid = 1'b0;
    step();

    // Back-to-back full load of 0xA5 pixels and 0x3C weights
    state = s_LOAD;
    send_byte(0, 8'hA5);
    c0 = cyc;
    for (int k = 1; k < 98; k++) send_byte(k, 8'hA5);
    for (int k = 98; k < 106; k++) send_byte(k, 8'h3C);
    check("done_early", {783'b0, load_done}, 784'd0);
    send_byte(106, 8'h3C);
    check("b2b_cycles", 784'(cyc - c0), 784'd106);
    check("done_set", {783'b0, load_done}, 784'd1);
    check("pix00", {783'b0, pixels[0][0]}, 784'd1);
    check("pix01", {783'b0, pixels[0][1]}, 784'd0);
    check("w000", {783'b0, weights[0][0][0]}, 784'd0);
    check("w002", {783'b0, weights[0][0][2]}, 784'd1);
    check("a5_pix", pix_flat, exp_pix);
    check("3c_wgt", {712'b0, wgt_flat}, {712'b0, exp_wgt});

    // Extra bytes after done are ignored
    snap_pix = pix_flat;
    snap_wgt = wgt_flat;
    ld.data_valid = 1'b1;
    ld.data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("done_ready", {783'b0, ld.data_ready}, 784'd0);
      step();
    end
    check("extra_pix", pix_flat, snap_pix);
    check("extra_wgt", {712'b0, wgt_flat}, {712'b0, snap_wgt});
    check("done_hold", {783'b0, load_done}, 784'd1);
    state = s_IDLE;
    check("done_still", {783'b0, load_done}, 784'd1);
    step();
    check("done_clear", {783'b0, load_done}, 784'd0);

    // Valid bytes while not in s_LOAD change nothing
    ld.data_valid = 1'b1;
    ld.data_in = 8'h5F;
    for (int i = 0; i < 20; i++) begin
      check("idle_ready", {783'b0, ld.data_ready}, 784'd0);
      step();
    end
    check("idle_pix", pix_flat, exp_pix);
    check("idle_wgt", {712'b0, wgt_flat}, {712'b0, exp_wgt});
    ld.data_valid = 1'b0;

    // Counting pattern with random valid gaps
    state = s_LOAD;
    for (int k = 0; k < 107; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        ld.data_valid = 1'b0;
        step();
      end
      send_byte(k, 8'(k));
    end
    ld.data_valid = 1'b0;
    check("cnt_pix", pix_flat, exp_pix);
    check("cnt_wgt", {712'b0, wgt_flat}, {712'b0, exp_wgt});
    check("cnt_ready", {783'b0, ld.data_ready}, 784'd0);
    check("cnt_done", {783'b0, load_done}, 784'd1);
    leave_load();

    // Abort after 50 bytes, then full reload of 0xFF
    state = s_LOAD;
    for (int k = 0; k < 50; k++) send_byte(k, 8'hFF);
    leave_load();
    step();
    check("abort_done", {783'b0, load_done}, 784'd0);
    check("abort_pix", pix_flat, exp_pix);
    check("abort_wgt", {712'b0, wgt_flat}, {712'b0, exp_wgt});
    state = s_LOAD;
    for (int k = 0; k < 107; k++) send_byte(k, 8'hFF);
    ld.data_valid = 1'b0;
    check("ff_pix", pix_flat, {784{1'b1}});
    check("ff_wgt", {712'b0, wgt_flat}, {712'b0, {72{1'b1}}});
    check("ff_done", {783'b0, load_done}, 784'd1);
    leave_load();

    // Reset collides with pixel byte 40
    state = s_LOAD;
    for (int k = 0; k < 40; k++) send_byte(k, 8'h5A);
    ld.data_valid = 1'b1;
    ld.data_in = 8'h77;
    check("b40_ready", {783'b0, ld.data_ready}, 784'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ld.data_valid = 1'b0;
    exp_pix = '0;
    exp_wgt = '0;
    check("rst40_pix", pix_flat, 784'd0);
    check("rst40_wgt", {712'b0, wgt_flat}, 784'd0);
    check("rst40_done", {783'b0, load_done}, 784'd0);
    check("rst40_ready", {783'b0, ld.data_ready}, 784'd0);
    send_byte(0, 8'h81);
    check("restart_pix", pix_flat, exp_pix);
    leave_load();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bnn_input_loader.md
BNN_INPUT_LOADER -- requirements
Module: bnn_input_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: state  input  state_t (3)  top-level phase; loader accepts data only in s_LOAD.
REQ-004 SHALL have port: data_in  input  8  one load byte.
REQ-005 SHALL have port: data_valid  input  1  data_in valid this cycle.
REQ-006 SHALL have port: data_ready  output  1  loader will accept a byte this cycle.
REQ-007 SHALL have port: pixels  output  [27:0][27:0] packed  binarised image; pixels[r][c] = flat bit r*28+c.
REQ-008 SHALL have port: weights  output  [7:0][2:0][2:0] packed  layer-one kernels; weights[n][i][j] = flat bit n*9+i*3+j.
REQ-009 SHALL have port: load_done  output  1  full image and weight set captured.
REQ-010 SHALL have parameters: N_PIX_BYTES, default 98, pixel bytes per load; N_WGT_BYTES, default 9, weight bytes per load.

Function
REQ-011 SHALL transfer a byte on every cycle where data_valid && data_ready; no other byte affects state or storage.
REQ-012 SHALL drive data_ready = (state == s_LOAD) && (fsm in L_PIX or L_WGT), combinationally.
REQ-013 SHALL run FSM states L_IDLE, L_PIX, L_WGT, L_DONE.
REQ-014 L_IDLE -> L_PIX SHALL occur on the first cycle state == s_LOAD; byte_cnt cleared to 0.
REQ-015 L_PIX SHALL write transferred byte k (0..97) into pixel flat bits 8k..8k+7, with data_in[b] written to bit 8k+b.
REQ-016 L_PIX -> L_WGT SHALL occur on transfer of byte 97; byte_cnt cleared to 0.
REQ-017 L_WGT SHALL write transferred byte w (0..8) into weight flat bits 8w..8w+7, with data_in[b] written to bit 8w+b.
REQ-018 L_WGT -> L_DONE SHALL occur on transfer of byte 8; load_done rises the following cycle (registered).
REQ-019 L_DONE SHALL hold load_done = 1 and data_ready = 0; further data_valid is ignored.
REQ-020 Any FSM state SHALL return to L_IDLE, with load_done cleared, on the cycle after state != s_LOAD.
REQ-021 A return to L_IDLE SHALL retain pixels and weights, which stay stable for downstream layers.
REQ-022 Leaving s_LOAD mid-load SHALL abandon the partial load; the next s_LOAD entry restarts at pixel byte 0, and previously written bits remain until overwritten.
REQ-023 byte_cnt SHALL be 7 bits, never exceed 97, and never wrap.
REQ-024 Total load latency SHALL be exactly 107 transfers plus 1 cycle to load_done; idle data_valid gaps insert cycles without corrupting order.
REQ-025 pixels and weights SHALL change only on a transfer cycle.

Reset
REQ-026 rst SHALL put the FSM in L_IDLE, byte_cnt = 0, load_done = 0, pixels = 0, weights = 0; data_ready then evaluates to 0.
REQ-027 rst SHALL have priority over a simultaneous transfer; that byte is dropped.

Structure
REQ-028 state_t (s_IDLE=0, s_LOAD=1, s_LAYER_1=2, s_LAYER_2=3, s_LAYER_3=4) and the N_PIX_BYTES/N_WGT_BYTES defaults SHALL live in shared package bnn_pkg.
REQ-029 The loader FSM encoding SHALL be local to the module.
REQ-030 The block SHALL be a single module with no sub-modules; storage is flat registers indexed by byte_cnt.

Verification
REQ-031 Reset, then state = s_LOAD with 107 back-to-back bytes: pixel bytes 0xA5, weight bytes 0x3C -> pixels[0][0] = 1, pixels[0][1] = 0; weights[0][0][0] = 0, weights[0][0][2] = 1; load_done = 1 on cycle 108.
REQ-032 Random data_valid gaps (50% duty) with a counting pattern, byte k = k -> pixels and weights match the golden flat map; data_ready = 0 after the last byte.
REQ-033 data_valid = 1 with state = s_IDLE for 20 cycles -> no bits change; data_ready = 0.
REQ-034 Drop state to s_IDLE after 50 bytes, then reload 107 bytes of 0xFF -> all pixels = 1, all weights = 1, load_done = 1.
REQ-035 Assert rst on the same cycle as pixel byte 40 -> all outputs 0 next cycle; the byte is not stored.
REQ-036 After load_done, send 5 extra valid bytes of 0x00 -> pixels and weights unchanged; load_done stays 1 until state leaves s_LOAD, then is 0 one cycle later.
